frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Shares the single SDRAM controller port among three clients: camera pixel FIFO drain (write), Sobel result FIFO drain (write), and the display line fetcher (read). Sits between `camera_interface` FIFOs and the SDRAM controller. Issues fixed-length bursts and keeps a wrapping frame address per client.

## Interface
- `BURST_LEN`, 64: words per burst; power of two, at most 512.
- `FRAME_WORDS`, 76800: words per frame (320x240); multiple of `BURST_LEN`.
- `ADDR_W`, 24: SDRAM word-address width.
- `CAM_BASE`, 24'h000000: camera frame base address.
- `SOB_BASE`, 24'h020000: Sobel frame base address.
---
- `clk`  in  1  system clock (100 MHz domain).
- `rst`  in  1  asynchronous, active-high reset.
- `cam_count`  in  11  camera FIFO fill level (FWFT FIFO).
- `cam_dout`  in  17  camera FIFO head word; [15:0] stored, [16] ignored.
- `cam_rd_en`  out  1  camera FIFO pop.
- `cam_frame_start`  in  1  one-cycle pulse at camera VSYNC.
- `sob_count`  in  10  Sobel FIFO fill level (FWFT FIFO).
- `sob_dout`  in  17  Sobel FIFO head word; [15:0] stored.
- `sob_rd_en`  out  1  Sobel FIFO pop.
- `sob_frame_start`  in  1  Sobel frame-start pulse.
- `disp_req`  in  1  level; display wants one burst.
- `disp_sel`  in  1  0 = read camera frame, 1 = read Sobel frame; sampled at grant.
- `disp_frame_start`  in  1  display frame-start pulse.
- `disp_data`  out  16  read data to the display.
- `disp_valid`  out  1  `disp_data` qualifier.
- `mem_cmd_valid`/`mem_cmd_ready`  out/in  1  command handshake.
- `mem_cmd_we`  out  1  1 = write burst.
- `mem_cmd_addr`  out  ADDR_W  burst start address.
- `mem_wdata`  out  16  write word.
- `mem_wdata_req`  in  1  controller consumes `mem_wdata` this cycle.
- `mem_rdata`/`mem_rdata_valid`  in  16/1  read return.
- `grant`  out  2  0 none, 1 cam, 2 sob, 3 disp (debug).

## Operation
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE selects a client when one is eligible, latches `grant`, and goes to CMD.
  - Display is eligible when `disp_req` = 1. It has fixed highest priority.
  - Camera is eligible when `cam_count >= BURST_LEN`. Sobel is eligible when `sob_count >= BURST_LEN`.
  - Camera and Sobel share round-robin; the last served write client loses a tie.
- CMD holds `mem_cmd_valid` high until `mem_cmd_ready`. Then write → WDATA, read → RDATA.
- WDATA: `mem_wdata` shows the granted FIFO's `dout[15:0]`, combinationally.
  - The FIFO pop equals `mem_wdata_req`.
  - After `BURST_LEN` pops, return to IDLE.
- RDATA: `disp_data` and `disp_valid` forward `mem_rdata` and `mem_rdata_valid` combinationally.
  - After `BURST_LEN` valid words, return to IDLE.
- Address generation:
  - Each client keeps an offset. Address = base + offset.
  - The display base comes from `disp_sel`, latched at grant.
  - After a burst completes, offset += `BURST_LEN`. When the result equals `FRAME_WORDS`, it wraps to 0.
- Frame start:
  - A pulse sets a pending flag for that client.
  - The flag clears the offset to 0 in IDLE, before the next arbitration, never mid-burst.
  - A pulse in the same cycle as burst completion yields offset 0.
- `mem_wdata_req` or `mem_rdata_valid` outside WDATA/RDATA: ignored. `cam_rd_en`/`sob_rd_en` stay 0.

## Timing
- Reset values: state IDLE; all offsets 0; pending flags 0; `grant` 0; round-robin pointer = camera first.
- Reset outputs: `mem_cmd_valid`, `cam_rd_en`, `sob_rd_en`, `disp_valid` = 0; `mem_cmd_addr`, `mem_wdata`, `disp_data` = 0.
- Request to `mem_cmd_valid`: 1 cycle (IDLE registers the grant).
- Last data beat to next `mem_cmd_valid`: 2 cycles minimum.
- Pop lands in the same cycle as `mem_wdata_req`; no extra buffering.
- Reset asserted mid-burst aborts immediately. The SDRAM controller is reset by the same `rst`.

## Configuration
- `FBARB_SOBEL_PORT_EN` defined: all three clients, as above.
- Undefined: Sobel client removed.
  - `sob_rd_en` tied 0; `sob_*` inputs unused.
  - `disp_sel` ignored; display always reads `CAM_BASE`.
  - Camera write is the only write client.

## Structure
- `frame_arb_pkg` holds:
  - the state enum;
  - the client IDs (NONE/CAM/SOB/DISP) used on `grant`;
  - `DATA_W` = 16.
- One sub-module, `burst_addr_gen`, instantiated per client.
  - Contents: offset counter, wrap at `FRAME_WORDS`, frame-start pending flag, and increment/clear strobes from the FSM.

## Test plan
- `cam_count` = 64, controller always ready → one write command at 0x000000; 64 `cam_rd_en` pulses; `grant` = 1, then 0.
- Camera and Sobel both at 64 for four bursts → grants alternate cam, sob, cam, sob; addresses 0x000000, 0x020000, 0x000040, 0x020040.
- `disp_req` asserted together with `cam_count` = 64 → display wins; `mem_cmd_we` = 0; exactly 64 `disp_valid` beats; camera served next.
- 1200 camera bursts → the 1201st burst addresses 0x000000 (wrap at 76800).
- `cam_frame_start` mid-burst at offset 0x80 → the current burst completes at 0x80; the next burst is at 0x000000.
- `rst` during WDATA after 10 pops → all strobes 0 in the same cycle; after release, `grant` = 0 and the next burst is at base + 0.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// Shared types for the SDRAM frame-buffer arbiter: FSM states, client IDs and data width.
package frame_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_NONE = 2'd0,
        CL_CAM  = 2'd1,
        CL_SOB  = 2'd2,
        CL_DISP = 2'd3
    } client_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Per-client frame offset: steps by one burst, wraps at the frame size, and restarts at 0
// in IDLE once a frame-start pulse has been seen.
module burst_addr_gen #(
    parameter int BURST_LEN   = 64,
    parameter int FRAME_WORDS = 76800,
    parameter int ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              clear,
    input  logic              incr,
    output logic [ADDR_W-1:0] offset
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] WRAP = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] offset_r;
    logic [ADDR_W-1:0] offset_n;
    logic [ADDR_W-1:0] offset_inc_s;
    logic              pending_r;
    logic              pending_n;
    logic              restart_s;

    // Next offset / pending flag; a pulse during a burst only arms the flag.
    always_comb begin
        restart_s    = pending_r | frame_start;
        offset_inc_s = offset_r + STEP;
        offset_n     = offset_r;
        pending_n    = pending_r | frame_start;
        if (clear && restart_s) begin
            offset_n  = {ADDR_W{1'b0}};
            pending_n = 1'b0;
        end else if (incr) begin
            if (offset_inc_s == WRAP) begin
                offset_n = {ADDR_W{1'b0}};
            end else begin
                offset_n = offset_inc_s;
            end
        end else begin
            offset_n = offset_r;
        end
        offset = restart_s ? {ADDR_W{1'b0}} : offset_r;
    end

    // Offset and pending-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_r  <= {ADDR_W{1'b0}};
            pending_r <= 1'b0;
        end else begin
            offset_r  <= offset_n;
            pending_r <= pending_n;
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates the single SDRAM controller port between camera/Sobel write drains and the display
// reader. Optional Sobel client is enabled by defining FBARB_SOBEL_PORT_EN.
module frame_buffer_arbiter
    import frame_arb_pkg::*;
#(
    parameter int                BURST_LEN   = 64,
    parameter int                FRAME_WORDS = 76800,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] CAM_BASE    = 24'h000000,
    parameter logic [ADDR_W-1:0] SOB_BASE    = 24'h020000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       cam_count,
    input  logic [16:0]       cam_dout,
    output logic              cam_rd_en,
    input  logic              cam_frame_start,
    input  logic [9:0]        sob_count,
    input  logic [16:0]       sob_dout,
    output logic              sob_rd_en,
    input  logic              sob_frame_start,
    input  logic              disp_req,
    input  logic              disp_sel,
    input  logic              disp_frame_start,
    output logic [15:0]       disp_data,
    output logic              disp_valid,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_wdata_req,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rdata_valid,
    output logic [1:0]        grant
);

    localparam logic [10:0] CAM_THR   = 11'(BURST_LEN);
    localparam logic [9:0]  SOB_THR   = 10'(BURST_LEN);
    localparam logic [9:0]  LAST_BEAT = 10'(BURST_LEN - 1);

    state_t            state_r, state_n;
    client_t           grant_r, grant_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [9:0]        beat_r, beat_n;
    logic              last_sob_r, last_sob_n;
    logic              clear_s, done_s, beat_s;
    logic              cam_inc_s, sob_inc_s, disp_inc_s, sob_pop_s;
    logic              cam_elig_s, sob_elig_s;
    logic [ADDR_W-1:0] cam_off_s, sob_off_s, disp_off_s, disp_base_s;
    logic [DATA_W-1:0] sob_word_s;

    assign cam_elig_s = (cam_count >= CAM_THR);

`ifdef FBARB_SOBEL_PORT_EN
    logic unused_s;
    assign sob_elig_s  = (sob_count >= SOB_THR);
    assign disp_base_s = disp_sel ? SOB_BASE : CAM_BASE;
    assign sob_word_s  = sob_dout[DATA_W-1:0];
    assign sob_rd_en   = sob_pop_s;
    assign unused_s    = cam_dout[16] ^ sob_dout[16];

    burst_addr_gen #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_sob_addr (
        .clk(clk), .rst(rst), .frame_start(sob_frame_start),
        .clear(clear_s), .incr(sob_inc_s), .offset(sob_off_s)
    );
`else
    logic unused_s;
    assign sob_elig_s  = 1'b0;
    assign disp_base_s = CAM_BASE;
    assign sob_word_s  = {DATA_W{1'b0}};
    assign sob_off_s   = {ADDR_W{1'b0}};
    assign sob_rd_en   = 1'b0;
    assign unused_s    = ^{sob_count, sob_dout, sob_frame_start, disp_sel, cam_dout[16],
                           SOB_BASE, sob_inc_s, sob_pop_s};
`endif

    burst_addr_gen #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_cam_addr (
        .clk(clk), .rst(rst), .frame_start(cam_frame_start),
        .clear(clear_s), .incr(cam_inc_s), .offset(cam_off_s)
    );

    burst_addr_gen #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_disp_addr (
        .clk(clk), .rst(rst), .frame_start(disp_frame_start),
        .clear(clear_s), .incr(disp_inc_s), .offset(disp_off_s)
    );

    // Next-state, arbitration and datapath steering; writers alternate, display always wins.
    always_comb begin
        state_n       = state_r;
        grant_n       = grant_r;
        addr_n        = addr_r;
        beat_n        = beat_r;
        last_sob_n    = last_sob_r;
        clear_s       = 1'b0;
        beat_s        = 1'b0;
        mem_cmd_valid = 1'b0;
        cam_rd_en     = 1'b0;
        sob_pop_s     = 1'b0;
        mem_wdata     = {DATA_W{1'b0}};
        disp_data     = {DATA_W{1'b0}};
        disp_valid    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = 1'b1;
                beat_n  = 10'd0;
                if (disp_req) begin
                    grant_n = CL_DISP;
                    addr_n  = disp_base_s + disp_off_s;
                    state_n = ST_CMD;
                end else if (cam_elig_s && (!sob_elig_s || last_sob_r)) begin
                    grant_n    = CL_CAM;
                    addr_n     = CAM_BASE + cam_off_s;
                    last_sob_n = 1'b0;
                    state_n    = ST_CMD;
                end else if (sob_elig_s) begin
                    grant_n    = CL_SOB;
                    addr_n     = SOB_BASE + sob_off_s;
                    last_sob_n = 1'b1;
                    state_n    = ST_CMD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_n = (grant_r == CL_DISP) ? ST_RDATA : ST_WDATA;
                end else begin
                    state_n = ST_CMD;
                end
            end
            ST_WDATA: begin
                mem_wdata = (grant_r == CL_SOB) ? sob_word_s : cam_dout[DATA_W-1:0];
                cam_rd_en = mem_wdata_req && (grant_r == CL_CAM);
                sob_pop_s = mem_wdata_req && (grant_r == CL_SOB);
                beat_s    = mem_wdata_req;
            end
            ST_RDATA: begin
                disp_data  = mem_rdata;
                disp_valid = mem_rdata_valid;
                beat_s     = mem_rdata_valid;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = CL_NONE;
            end
        endcase

        done_s = beat_s && (beat_r == LAST_BEAT);
        if (done_s) begin
            state_n = ST_IDLE;
            grant_n = CL_NONE;
        end else if (beat_s) begin
            beat_n = beat_r + 10'd1;
        end else begin
            beat_n = (state_r == ST_IDLE) ? 10'd0 : beat_r;
        end
        cam_inc_s  = done_s && (grant_r == CL_CAM);
        sob_inc_s  = done_s && (grant_r == CL_SOB);
        disp_inc_s = done_s && (grant_r == CL_DISP);
    end

    assign mem_cmd_we   = (grant_r != CL_DISP);
    assign mem_cmd_addr = addr_r;
    assign grant        = grant_r;

    // FSM, grant, latched burst address, beat counter and round-robin memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= CL_NONE;
            addr_r     <= {ADDR_W{1'b0}};
            beat_r     <= 10'd0;
            last_sob_r <= 1'b1;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            addr_r     <= addr_n;
            beat_r     <= beat_n;
            last_sob_r <= last_sob_n;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed self-checking bench for frame_buffer_arbiter; Sobel scenarios follow FBARB_SOBEL_PORT_EN.
module tb_frame_buffer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cam_count;
    logic [16:0] cam_dout;
    logic        cam_rd_en;
    logic        cam_frame_start;
    logic [9:0]  sob_count;
    logic [16:0] sob_dout;
    logic        sob_rd_en;
    logic        sob_frame_start;
    logic        disp_req;
    logic        disp_sel;
    logic        disp_frame_start;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_we;
    logic [23:0] mem_cmd_addr;
    logic [15:0] mem_wdata;
    logic        mem_wdata_req;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter dut (
        .clk(clk), .rst(rst),
        .cam_count(cam_count), .cam_dout(cam_dout), .cam_rd_en(cam_rd_en),
        .cam_frame_start(cam_frame_start),
        .sob_count(sob_count), .sob_dout(sob_dout), .sob_rd_en(sob_rd_en),
        .sob_frame_start(sob_frame_start),
        .disp_req(disp_req), .disp_sel(disp_sel), .disp_frame_start(disp_frame_start),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata), .mem_wdata_req(mem_wdata_req),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .grant(grant)
    );

    task automatic apply_reset();
        cam_count = 11'd0; cam_dout = 17'd0; cam_frame_start = 1'b0;
        sob_count = 10'd0; sob_dout = 17'd0; sob_frame_start = 1'b0;
        disp_req = 1'b0; disp_sel = 1'b0; disp_frame_start = 1'b0;
        mem_cmd_ready = 1'b0; mem_wdata_req = 1'b0; mem_rdata = 16'd0; mem_rdata_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one burst as the controller: waits for the command, accepts it, supplies 64 beats.
    task automatic do_burst(input string tag, input logic [1:0] exp_grant,
                            input logic [23:0] exp_addr, input int fs_beat);
        logic        exp_we;
        logic [15:0] exp_d;
        logic [15:0] got_d;
        int          good_pops;
        int          bad_pops;
        bit          seen;
        exp_we = (exp_grant != 2'd3);
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_cmd_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_cmd_timeout: mem_cmd_valid=%b required 1", tag, mem_cmd_valid);
            return;
        end
        n_cmp++;
        if (grant !== exp_grant) begin
            n_bad++; $display("FAIL %s_grant: got %0d expected %0d", tag, grant, exp_grant);
        end
        n_cmp++;
        if (mem_cmd_addr !== exp_addr) begin
            n_bad++; $display("FAIL %s_addr: got %h expected %h", tag, mem_cmd_addr, exp_addr);
        end
        n_cmp++;
        if (mem_cmd_we !== exp_we) begin
            n_bad++; $display("FAIL %s_we: got %b expected %b", tag, mem_cmd_we, exp_we);
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        good_pops = 0;
        bad_pops  = 0;
        for (int i = 0; i < 64; i++) begin
            if (i % 16 == 5) begin
                mem_wdata_req = 1'b0; mem_rdata_valid = 1'b0;
                #1;
                n_cmp++;
                if ((cam_rd_en | sob_rd_en | disp_valid) !== 1'b0) begin
                    n_bad++; $display("FAIL %s_stray_strobe: beat %0d got %b%b%b expected 000",
                                      tag, i, cam_rd_en, sob_rd_en, disp_valid);
                end
                @(negedge clk);
            end
            cam_dout  = {1'b1, 16'hC000 + 16'(i)};
            sob_dout  = {1'b1, 16'h5000 + 16'(i)};
            mem_rdata = 16'hD000 + 16'(i);
            if (exp_we) mem_wdata_req = 1'b1;
            else        mem_rdata_valid = 1'b1;
            if (i == fs_beat) cam_frame_start = 1'b1;
            #1;
            if (exp_grant == 2'd1) begin
                good_pops += int'(cam_rd_en); bad_pops += int'(sob_rd_en) + int'(disp_valid);
                exp_d = 16'hC000 + 16'(i); got_d = mem_wdata;
            end else if (exp_grant == 2'd2) begin
                good_pops += int'(sob_rd_en); bad_pops += int'(cam_rd_en) + int'(disp_valid);
                exp_d = 16'h5000 + 16'(i); got_d = mem_wdata;
            end else begin
                good_pops += int'(disp_valid); bad_pops += int'(cam_rd_en) + int'(sob_rd_en);
                exp_d = 16'hD000 + 16'(i); got_d = disp_data;
            end
            n_cmp++;
            if (got_d !== exp_d) begin
                n_bad++; $display("FAIL %s_data: beat %0d got %h expected %h", tag, i, got_d, exp_d);
            end
            @(negedge clk);
            cam_frame_start = 1'b0;
        end
        mem_wdata_req = 1'b0; mem_rdata_valid = 1'b0;
        #1;
        n_cmp++;
        if (good_pops != 64 || bad_pops != 0) begin
            n_bad++; $display("FAIL %s_beats: got %0d/%0d wrong expected 64/0", tag, good_pops, bad_pops);
        end
        n_cmp++;
        if (grant !== 2'd0 || mem_cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_after: grant=%0d valid=%b expected 0/0", tag, grant, mem_cmd_valid);
        end
    endtask

    task automatic test_reset();
        cam_count = 11'd0; sob_count = 10'd0; disp_req = 1'b0;
        mem_wdata_req = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 16'hBEEF; cam_dout = 17'h1ABCD;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_cmd_valid, cam_rd_en, sob_rd_en, disp_valid, grant} !== 6'd0) begin
            n_bad++; $display("FAIL reset_strobes: got %b expected 000000",
                              {mem_cmd_valid, cam_rd_en, sob_rd_en, disp_valid, grant});
        end
        n_cmp++;
        if ({mem_cmd_addr, mem_wdata, disp_data} !== 56'd0) begin
            n_bad++; $display("FAIL reset_data: addr=%h wdata=%h disp=%h expected 0",
                              mem_cmd_addr, mem_wdata, disp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cam_rd_en, disp_valid, mem_wdata, disp_data} !== 34'd0) begin
            n_bad++; $display("FAIL idle_ignore: rd=%b dv=%b wdata=%h disp=%h expected 0",
                              cam_rd_en, disp_valid, mem_wdata, disp_data);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        apply_reset();
        cam_count = 11'd64;
        @(negedge clk);
        n_cmp++;
        if (mem_cmd_valid !== 1'b1 || grant !== 2'd1) begin
            n_bad++; $display("FAIL req_latency: valid=%b grant=%0d expected 1/1", mem_cmd_valid, grant);
        end
        cam_count = 11'd63;
        do_burst("single", 2'd1, 24'h000000, -1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (mem_cmd_valid !== 1'b0 || grant !== 2'd0) begin
            n_bad++; $display("FAIL below_thresh: valid=%b grant=%0d expected 0/0", mem_cmd_valid, grant);
        end
    endtask

`ifdef FBARB_SOBEL_PORT_EN
    task automatic test_round_robin();
        apply_reset();
        cam_count = 11'd64; sob_count = 10'd64;
        do_burst("rr0", 2'd1, 24'h000000, -1);
        do_burst("rr1", 2'd2, 24'h020000, -1);
        do_burst("rr2", 2'd1, 24'h000040, -1);
        do_burst("rr3", 2'd2, 24'h020040, -1);
        cam_count = 11'd0; sob_count = 10'd0;
    endtask
`else
    task automatic test_back_to_back();
        apply_reset();
        sob_count = 10'd512; disp_sel = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (mem_cmd_valid !== 1'b0 || grant !== 2'd0 || sob_rd_en !== 1'b0) begin
            n_bad++; $display("FAIL sob_disabled: valid=%b grant=%0d rd=%b expected 0/0/0",
                              mem_cmd_valid, grant, sob_rd_en);
        end
        cam_count = 11'd64;
        do_burst("b2b0", 2'd1, 24'h000000, -1);
        do_burst("b2b1", 2'd1, 24'h000040, -1);
        cam_count = 11'd0;
    endtask
`endif

    task automatic test_disp_priority();
        logic [23:0] exp_disp_addr;
`ifdef FBARB_SOBEL_PORT_EN
        exp_disp_addr = 24'h020000;
`else
        exp_disp_addr = 24'h000000;
`endif
        apply_reset();
        disp_req = 1'b1; disp_sel = 1'b1; cam_count = 11'd64;
        @(negedge clk);
        disp_req = 1'b0; disp_sel = 1'b0;
        do_burst("disp", 2'd3, exp_disp_addr, -1);
        @(negedge clk);
        n_cmp++;
        if (mem_cmd_valid !== 1'b1) begin
            n_bad++; $display("FAIL gap_two_cycles: valid=%b expected 1", mem_cmd_valid);
        end
        do_burst("after_disp", 2'd1, 24'h000000, -1);
        cam_count = 11'd0;
    endtask

    task automatic test_frame_start();
        apply_reset();
        cam_count = 11'd64;
        do_burst("fs0", 2'd1, 24'h000000, -1);
        do_burst("fs1", 2'd1, 24'h000040, -1);
        do_burst("fs_mid", 2'd1, 24'h000080, 10);
        do_burst("fs_restart", 2'd1, 24'h000000, -1);
        do_burst("fs_last", 2'd1, 24'h000040, 63);
        do_burst("fs_edge", 2'd1, 24'h000000, -1);
        cam_count = 11'd0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        cam_count = 11'd64;
        do_burst("rst_pre", 2'd1, 24'h000000, -1);
        n_cmp++;
        if (mem_cmd_addr !== 24'h000000) begin
            n_bad++; $display("FAIL rst_pre_hold: addr=%h expected 000000", mem_cmd_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 24'h000040) begin
            n_bad++; $display("FAIL rst_second_cmd: valid=%b addr=%h expected 1/000040",
                              mem_cmd_valid, mem_cmd_addr);
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        mem_wdata_req = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cam_rd_en, sob_rd_en, mem_cmd_valid, grant} !== 5'd0 || mem_wdata !== 16'd0) begin
            n_bad++; $display("FAIL rst_abort: rd=%b%b valid=%b grant=%0d wdata=%h expected 0",
                              cam_rd_en, sob_rd_en, mem_cmd_valid, grant, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0; mem_wdata_req = 1'b0;
        #1;
        n_cmp++;
        if (grant !== 2'd0) begin
            n_bad++; $display("FAIL rst_release_grant: got %0d expected 0", grant);
        end
        do_burst("rst_post", 2'd1, 24'h000000, -1);
        cam_count = 11'd0;
    endtask

    task automatic test_wrap();
        int  exp_off;
        bit  seen;
        apply_reset();
        cam_count = 11'd64; mem_cmd_ready = 1'b1; mem_wdata_req = 1'b1;
        exp_off = 0;
        for (int b = 0; b <= 1200; b++) begin
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (mem_cmd_valid === 1'b1) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            n_cmp++;
            if (!seen) begin
                n_bad++; $display("FAIL wrap_timeout: burst %0d valid=%b required 1", b, mem_cmd_valid);
                break;
            end
            n_cmp++;
            if (mem_cmd_addr !== 24'(exp_off)) begin
                n_bad++; $display("FAIL wrap_addr: burst %0d got %h expected %h", b, mem_cmd_addr, 24'(exp_off));
            end
            exp_off = (exp_off + 64) % 76800;
            @(negedge clk);
        end
        cam_count = 11'd0; mem_cmd_ready = 1'b0; mem_wdata_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
`ifdef FBARB_SOBEL_PORT_EN
        test_round_robin();
`else
        test_back_to_back();
`endif
        test_disp_priority();
        test_frame_start();
        test_reset_mid_burst();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
